alu_unit: RTL and testbench
===========================

# alu_unit

Execution unit directly downstream of the reservation station. It accepts one dispatched instruction per cycle with operands already resolved, computes the result, and broadcasts it on the ALU CDB port as `aluReady`/`entry_out`/`val_out` to the ROB, the reservation station and the LSB. It resolves branches and JALR, sending a one-cycle redirect to ifetch. When `ALU_MUL_EN` is compiled in, it also runs a multi-cycle RV32M multiplier.

## Interface
- `VAL_W`, default 32: operand and result width.
- `ROB_ID_W`, default 4: ROB tag is `ROB_ID_W+1` bits; tag 0 means "no tag".
- `OP_W`, default 7: instruction type width; encodings are the `OP_*` codes in util.v.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_in` input 1: reset, **asynchronous, active-high**.
- `rdy_in` input 1: global enable; all state holds while low.
- `flush` input 1: mispredict flush; aborts the instruction in flight.
- `execute` input 1: dispatch strobe from the reservation station.
- `type` input `OP_W`: operation.
- `val1`, `val2` input `VAL_W`: rs1/rs2 values, or imm/PC for LUI, AUIPC and I-type.
- `imm` input `VAL_W`: branch/JALR offset.
- `pc` input `VAL_W`: PC of the dispatched instruction.
- `entry` input `ROB_ID_W+1`: ROB tag of the dispatched instruction.
- `busy` output 1: multiplier occupied; the reservation station must not dispatch.
- `aluReady` output 1: result valid, one-cycle pulse.
- `entry_out` output `ROB_ID_W+1`: tag of the result.
- `val_out` output `VAL_W`: result.
- `alu2if_con` output 1: redirect valid, one-cycle pulse.
- `alu2if_pc` output `VAL_W`: resolved next PC.

## Operation
- Results (all arithmetic is modulo 2^32, shift amount is `val2[4:0]`):
  - ADD/ADDI = val1+val2; SUB = val1−val2.
  - AND, OR, XOR: bitwise on val1, val2.
  - SLL, SRL, SRA.
  - SLT/SLTU = {31'b0, cmp}.
  - LUI = val1; AUIPC = val1+val2.
- JAL: `val_out = pc+4`. No redirect; ifetch already followed it.
- JALR: `val_out = pc+4`; redirect to `(val1+imm) & ~1`.
- BEQ, BNE, BLT, BGE, BLTU, BGEU:
  - `val_out` = 1 if taken, else 0.
  - `alu2if_pc` = pc+imm if taken, else pc+4.
  - `alu2if_con` pulses for every branch, taken or not.
- Unknown `type`: `val_out = 0`, `aluReady` still pulses so the ROB does not hang.
- FSM states are IDLE and MUL (MUL exists only with `ALU_MUL_EN`).
  - IDLE, `execute` with a non-MUL type: registered result, return to IDLE.
  - IDLE, `execute` with a MUL type: go to MUL, counter = 0.
  - MUL: one shift-add step per cycle, counter++. After step 31, write the result and return to IDLE.
- `execute` while `busy=1` is ignored. The bench asserts it never happens.
- `flush` (with `rdy_in`): next edge clears `aluReady`, `alu2if_con` and `busy`, and forces IDLE. An `execute` in the same cycle is discarded.
- Reset values:
  - `aluReady`, `alu2if_con`, `busy` = 0.
  - `entry_out` = 0, `val_out` = 0, `alu2if_pc` = 0.
  - FSM = IDLE, counter = 0.

## Timing
- Non-MUL: `execute` sampled at edge N. Outputs are valid from edge N+1 for exactly one cycle; there are no combinational paths from inputs to outputs.
- Back-to-back `execute` on consecutive cycles yields consecutive result pulses.
- MUL: `execute` at edge N.
  - `busy` is high from N+1 through N+32.
  - `aluReady` pulses after edge N+33; `busy` is low in that cycle.
- `rdy_in=0`: registers, outputs and the counter hold. Pulses stretch, and consumers qualify them with `rdy_in`.
- Flush takes priority over `execute` and over an in-progress multiply.
- Async reset mid-multiply: returns to IDLE immediately and no result is emitted.

## Configuration
- `ALU_MUL_EN` defined:
  - MUL, MULH, MULHSU and MULHU are supported.
  - The multiply takes the unsigned magnitudes, runs a 32-step shift-add into a 64-bit accumulator, then negates per operand signs.
  - MUL returns the low word; the others return the high word.
- `ALU_MUL_EN` undefined:
  - No MUL state and no counter; `busy` is tied to 0.
  - MUL types take the unknown-type path (`val_out = 0`, one-cycle latency).

## Test plan
- Reset, then ADD with val1=7, val2=0xFFFFFFFE, entry=3 → next cycle `aluReady=1`, `val_out=5`, `entry_out=3`; the cycle after, `aluReady=0`.
- SRA with val1=0x80000000, val2=0x24 → `val_out=0xF8000000` (shift amount 4).
- BLT with val1=−1, val2=1, pc=0x100, imm=0x20 → `val_out=1`, `alu2if_con=1`, `alu2if_pc=0x120`. BLTU with the same operands → `val_out=0`, `alu2if_pc=0x104`.
- JALR with val1=0x1003, imm=0, pc=0x40 → `val_out=0x44`, `alu2if_pc=0x1002`.
- With `ALU_MUL_EN`, MULH with val1=−2, val2=3 → `busy` high for 32 cycles, then `val_out=0xFFFFFFFF`. Repeat and assert `flush` at cycle 10 → no `aluReady`, `busy=0` the next cycle.
- Without `ALU_MUL_EN`, MUL with val1=6, val2=7 → one cycle later `aluReady=1`, `val_out=0`, and `busy` stays 0.

Source files
------------

// File: rtl/alu_unit.sv
// alu_unit: single-issue integer execution unit on the ALU CDB port.
// Results and branch/JALR redirects are registered, one cycle after dispatch.
// Optional RV32M multiplier is compiled in with `define ALU_MUL_EN; without it
// multiply opcodes take the unknown-opcode path and busy is tied low.
// The opcode input is named type_in because "type" is a reserved word.
module alu_unit #(
  parameter int unsigned VAL_W    = 32,
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned OP_W     = 7
) (
  input  logic                clk,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                flush,
  input  logic                execute,
  input  logic [OP_W-1:0]     type_in,
  input  logic [VAL_W-1:0]    val1,
  input  logic [VAL_W-1:0]    val2,
  input  logic [VAL_W-1:0]    imm,
  input  logic [VAL_W-1:0]    pc,
  input  logic [ROB_ID_W:0]   entry,
  output logic                busy,
  output logic                aluReady,
  output logic [ROB_ID_W:0]   entry_out,
  output logic [VAL_W-1:0]    val_out,
  output logic                alu2if_con,
  output logic [VAL_W-1:0]    alu2if_pc
);

  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(1);
  localparam logic [OP_W-1:0] OP_AUIPC = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_JALR  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(5);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6);
  localparam logic [OP_W-1:0] OP_BLT   = OP_W'(7);
  localparam logic [OP_W-1:0] OP_BGE   = OP_W'(8);
  localparam logic [OP_W-1:0] OP_BLTU  = OP_W'(9);
  localparam logic [OP_W-1:0] OP_BGEU  = OP_W'(10);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(11);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(12);
  localparam logic [OP_W-1:0] OP_SLTIU = OP_W'(13);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(14);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(15);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(16);
  localparam logic [OP_W-1:0] OP_SLLI  = OP_W'(17);
  localparam logic [OP_W-1:0] OP_SRLI  = OP_W'(18);
  localparam logic [OP_W-1:0] OP_SRAI  = OP_W'(19);
  localparam logic [OP_W-1:0] OP_ADD   = OP_W'(20);
  localparam logic [OP_W-1:0] OP_SUB   = OP_W'(21);
  localparam logic [OP_W-1:0] OP_SLL   = OP_W'(22);
  localparam logic [OP_W-1:0] OP_SLT   = OP_W'(23);
  localparam logic [OP_W-1:0] OP_SLTU  = OP_W'(24);
  localparam logic [OP_W-1:0] OP_XOR   = OP_W'(25);
  localparam logic [OP_W-1:0] OP_SRL   = OP_W'(26);
  localparam logic [OP_W-1:0] OP_SRA   = OP_W'(27);
  localparam logic [OP_W-1:0] OP_OR    = OP_W'(28);
  localparam logic [OP_W-1:0] OP_AND   = OP_W'(29);

  // Output registers
  logic                aluReady_q,   aluReady_d;
  logic                alu2if_con_q, alu2if_con_d;
  logic [ROB_ID_W:0]   entry_out_q,  entry_out_d;
  logic [VAL_W-1:0]    val_out_q,    val_out_d;
  logic [VAL_W-1:0]    alu2if_pc_q,  alu2if_pc_d;

  // Single-cycle datapath results
  logic [VAL_W-1:0]    alu_val;
  logic                br_con;
  logic [VAL_W-1:0]    br_pc;
  logic                accept;

  // Multiplier handshake (tied off when the multiplier is not built)
  logic                mul_done;
  logic [VAL_W-1:0]    mul_res;
  logic [ROB_ID_W:0]   mul_entry;

`ifdef ALU_MUL_EN
  localparam logic [OP_W-1:0] OP_MUL    = OP_W'(30);
  localparam logic [OP_W-1:0] OP_MULH   = OP_W'(31);
  localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(32);
  localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(33);
  localparam int unsigned CNT_W = $clog2(VAL_W);

  typedef enum logic [0:0] {S_IDLE, S_MUL} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*VAL_W-1:0]  acc_q, acc_d, acc_step, prod;
  logic [VAL_W-1:0]    mcand_q, mcand_d, mplier_q, mplier_d;
  logic                neg_q, neg_d, hi_q, hi_d;
  logic [ROB_ID_W:0]   tag_q, tag_d;
  logic                is_mul, start_mul, sgn1, sgn2, neg1, neg2;

  assign is_mul    = (type_in == OP_MUL) || (type_in == OP_MULH) ||
                     (type_in == OP_MULHSU) || (type_in == OP_MULHU);
  assign busy      = (state_q == S_MUL);
  assign start_mul = execute && !busy && is_mul;
  assign mul_done  = busy && (cnt_q == CNT_W'(VAL_W - 1));
  assign accept    = execute && !busy && !is_mul;
  assign mul_entry = tag_q;

  // FSM state register and multiplier working registers
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= 1'b0;
      tag_q    <= '0;
    end else if (rdy_in) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      tag_q    <= tag_d;
    end
  end

  // FSM next state; flush overrides both dispatch and an in-progress multiply
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_mul) state_d = S_MUL;
      S_MUL:   if (mul_done)  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Shift-add datapath: operand magnitudes loaded at dispatch, sign fixed at the end
  always_comb begin
    sgn1     = (type_in != OP_MULHU);
    sgn2     = (type_in == OP_MUL) || (type_in == OP_MULH);
    neg1     = sgn1 && val1[VAL_W-1];
    neg2     = sgn2 && val2[VAL_W-1];
    acc_step = acc_q + (mplier_q[cnt_q] ? ({{VAL_W{1'b0}}, mcand_q} << cnt_q) : '0);
    prod     = neg_q ? (~acc_step + 1'b1) : acc_step;
    mul_res  = hi_q ? prod[2*VAL_W-1:VAL_W] : prod[VAL_W-1:0];
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    tag_d    = tag_q;
    if (flush) begin
      cnt_d = '0;
    end else if (start_mul) begin
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = neg1 ? (~val1 + 1'b1) : val1;
      mplier_d = neg2 ? (~val2 + 1'b1) : val2;
      neg_d    = neg1 ^ neg2;
      hi_d     = (type_in != OP_MUL);
      tag_d    = entry;
    end else if (busy) begin
      acc_d = acc_step;
      cnt_d = mul_done ? '0 : cnt_q + 1'b1;
    end
  end
`else
  assign busy      = 1'b0;
  assign accept    = execute;
  assign mul_done  = 1'b0;
  assign mul_res   = '0;
  assign mul_entry = '0;
`endif

  // Single-cycle result, branch resolution and JALR target
  always_comb begin
    alu_val = '0;
    br_con  = 1'b0;
    br_pc   = '0;
    case (type_in)
      OP_LUI:            alu_val = val1;
      OP_AUIPC:          alu_val = val1 + val2;
      OP_ADD, OP_ADDI:   alu_val = val1 + val2;
      OP_SUB:            alu_val = val1 - val2;
      OP_AND, OP_ANDI:   alu_val = val1 & val2;
      OP_OR,  OP_ORI:    alu_val = val1 | val2;
      OP_XOR, OP_XORI:   alu_val = val1 ^ val2;
      OP_SLL, OP_SLLI:   alu_val = val1 << val2[4:0];
      OP_SRL, OP_SRLI:   alu_val = val1 >> val2[4:0];
      OP_SRA, OP_SRAI:   alu_val = VAL_W'($signed(val1) >>> val2[4:0]);
      OP_SLT, OP_SLTI:   alu_val = {{(VAL_W-1){1'b0}}, ($signed(val1) < $signed(val2))};
      OP_SLTU, OP_SLTIU: alu_val = {{(VAL_W-1){1'b0}}, (val1 < val2)};
      OP_JAL:            alu_val = pc + VAL_W'(4);
      OP_JALR: begin
        alu_val = pc + VAL_W'(4);
        br_con  = 1'b1;
        br_pc   = (val1 + imm) & ~VAL_W'(1);
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        case (type_in)
          OP_BEQ:  alu_val[0] = (val1 == val2);
          OP_BNE:  alu_val[0] = (val1 != val2);
          OP_BLT:  alu_val[0] = ($signed(val1) <  $signed(val2));
          OP_BGE:  alu_val[0] = ($signed(val1) >= $signed(val2));
          OP_BLTU: alu_val[0] = (val1 <  val2);
          default: alu_val[0] = (val1 >= val2);
        endcase
        br_con = 1'b1;
        br_pc  = alu_val[0] ? (pc + imm) : (pc + VAL_W'(4));
      end
      default:           alu_val = '0;
    endcase
  end

  // Next values of the CDB/redirect registers; pulses drop unless refreshed
  always_comb begin
    aluReady_d   = 1'b0;
    alu2if_con_d = 1'b0;
    entry_out_d  = entry_out_q;
    val_out_d    = val_out_q;
    alu2if_pc_d  = alu2if_pc_q;
    if (!flush) begin
      if (mul_done) begin
        aluReady_d  = 1'b1;
        entry_out_d = mul_entry;
        val_out_d   = mul_res;
      end else if (accept) begin
        aluReady_d   = 1'b1;
        entry_out_d  = entry;
        val_out_d    = alu_val;
        alu2if_con_d = br_con;
        if (br_con) alu2if_pc_d = br_pc;
      end
    end
  end

  // Output registers; everything holds while rdy_in is low
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      aluReady_q   <= 1'b0;
      alu2if_con_q <= 1'b0;
      entry_out_q  <= '0;
      val_out_q    <= '0;
      alu2if_pc_q  <= '0;
    end else if (rdy_in) begin
      aluReady_q   <= aluReady_d;
      alu2if_con_q <= alu2if_con_d;
      entry_out_q  <= entry_out_d;
      val_out_q    <= val_out_d;
      alu2if_pc_q  <= alu2if_pc_d;
    end
  end

  assign aluReady   = aluReady_q;
  assign alu2if_con = alu2if_con_q;
  assign entry_out  = entry_out_q;
  assign val_out    = val_out_q;
  assign alu2if_pc  = alu2if_pc_q;

endmodule

// File: tb/tb_alu_unit.sv
// Directed self-checking bench for alu_unit; covers the multiplier when
// ALU_MUL_EN is defined and the tied-off path otherwise.
module tb_alu_unit;

  localparam logic [6:0] T_LUI   = 7'd1;
  localparam logic [6:0] T_JAL   = 7'd3;
  localparam logic [6:0] T_JALR  = 7'd4;
  localparam logic [6:0] T_BEQ   = 7'd5;
  localparam logic [6:0] T_BLT   = 7'd7;
  localparam logic [6:0] T_BLTU  = 7'd9;
  localparam logic [6:0] T_ADD   = 7'd20;
  localparam logic [6:0] T_SUB   = 7'd21;
  localparam logic [6:0] T_SLT   = 7'd23;
  localparam logic [6:0] T_SLTU  = 7'd24;
  localparam logic [6:0] T_XOR   = 7'd25;
  localparam logic [6:0] T_SRL   = 7'd26;
  localparam logic [6:0] T_SRA   = 7'd27;
  localparam logic [6:0] T_MUL   = 7'd30;
  localparam logic [6:0] T_MULH  = 7'd31;
  localparam logic [6:0] T_MULHSU = 7'd32;
  localparam logic [6:0] T_MULHU = 7'd33;
  localparam logic [6:0] T_BAD   = 7'd127;

  logic        clk = 1'b0;
  logic        rst_in, rdy_in, flush, execute;
  logic [6:0]  type_in;
  logic [31:0] val1, val2, imm, pc;
  logic [4:0]  entry;
  logic        busy, aluReady, alu2if_con;
  logic [4:0]  entry_out;
  logic [31:0] val_out, alu2if_pc;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  alu_unit #(.VAL_W(32), .ROB_ID_W(4), .OP_W(7)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .execute(execute), .type_in(type_in), .val1(val1), .val2(val2),
    .imm(imm), .pc(pc), .entry(entry), .busy(busy), .aluReady(aluReady),
    .entry_out(entry_out), .val_out(val_out), .alu2if_con(alu2if_con),
    .alu2if_pc(alu2if_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one instruction for one edge; returns at the negedge where the result is visible
  task automatic dispatch(input logic [6:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] im, input logic [31:0] p, input logic [4:0] e);
    @(negedge clk);
    type_in = op; val1 = a; val2 = b; imm = im; pc = p; entry = e; execute = 1'b1;
    @(negedge clk);
    execute = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [31:0] v, input logic [4:0] e);
    check({tag, "_rdy"}, {31'b0, aluReady}, 32'd1);
    check({tag, "_val"}, val_out, v);
    check({tag, "_tag"}, {27'b0, entry_out}, {27'b0, e});
  endtask

  task automatic expect_branch(input string tag, input logic [31:0] v, input logic [31:0] npc);
    check({tag, "_rdy"}, {31'b0, aluReady}, 32'd1);
    check({tag, "_val"}, val_out, v);
    check({tag, "_con"}, {31'b0, alu2if_con}, 32'd1);
    check({tag, "_pc"},  alu2if_pc, npc);
  endtask

`ifdef ALU_MUL_EN
  // Runs a multiply and counts busy cycles, with a bound so the bench cannot hang
  task automatic run_mul(input string tag, input logic [6:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] e, input logic [31:0] exp);
    int unsigned nb;
    dispatch(op, a, b, 32'd0, 32'd0, e);
    nb = 0;
    while (busy && nb < 40) begin
      nb++;
      @(negedge clk);
    end
    check({tag, "_busycyc"}, nb, 32'd32);
    check({tag, "_busylow"}, {31'b0, busy}, 32'd0);
    expect_result(tag, exp, e);
  endtask
`endif

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; execute = 1'b0;
    type_in = '0; val1 = '0; val2 = '0; imm = '0; pc = '0; entry = '0;
    repeat (3) @(negedge clk);
    check("rst_rdy",  {31'b0, aluReady},   32'd0);
    check("rst_con",  {31'b0, alu2if_con}, 32'd0);
    check("rst_busy", {31'b0, busy},       32'd0);
    check("rst_tag",  {27'b0, entry_out},  32'd0);
    check("rst_val",  val_out,             32'd0);
    check("rst_pc",   alu2if_pc,           32'd0);
    rst_in = 1'b0;

    dispatch(T_ADD, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, 5'd3);
    expect_result("add", 32'd5, 5'd3);
    check("add_con", {31'b0, alu2if_con}, 32'd0);
    @(negedge clk);
    check("add_drop", {31'b0, aluReady}, 32'd0);

    dispatch(T_SRA, 32'h8000_0000, 32'h24, 32'd0, 32'd0, 5'd4);
    expect_result("sra", 32'hF800_0000, 5'd4);
    dispatch(T_SRL, 32'h8000_0000, 32'h24, 32'd0, 32'd0, 5'd5);
    expect_result("srl", 32'h0800_0000, 5'd5);
    dispatch(T_SUB, 32'd3, 32'd5, 32'd0, 32'd0, 5'd6);
    expect_result("sub", 32'hFFFF_FFFE, 5'd6);
    dispatch(T_XOR, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 32'd0, 5'd7);
    expect_result("xor", 32'h0000_0FF0, 5'd7);
    dispatch(T_SLT, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd8);
    expect_result("slt", 32'd1, 5'd8);
    dispatch(T_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 5'd9);
    expect_result("sltu", 32'd0, 5'd9);
    dispatch(T_LUI, 32'h1234_5000, 32'd0, 32'd0, 32'd0, 5'd10);
    expect_result("lui", 32'h1234_5000, 5'd10);

    dispatch(T_BLT, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd11);
    expect_branch("blt", 32'd1, 32'h120);
    dispatch(T_BLTU, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'h100, 5'd12);
    expect_branch("bltu", 32'd0, 32'h104);
    dispatch(T_BEQ, 32'd5, 32'd5, 32'hFFFF_FFF8, 32'h300, 5'd13);
    expect_branch("beq", 32'd1, 32'h2F8);
    dispatch(T_JALR, 32'h1003, 32'd0, 32'd0, 32'h40, 5'd14);
    expect_branch("jalr", 32'h44, 32'h1002);
    dispatch(T_JAL, 32'd0, 32'd0, 32'd0, 32'h200, 5'd15);
    expect_result("jal", 32'h204, 5'd15);
    check("jal_con", {31'b0, alu2if_con}, 32'd0);

    dispatch(T_BAD, 32'd9, 32'd9, 32'd0, 32'd0, 5'd16);
    expect_result("bad", 32'd0, 5'd16);

    // Back-to-back dispatch gives back-to-back pulses
    @(negedge clk);
    type_in = T_ADD; val1 = 32'd1; val2 = 32'd2; entry = 5'd1; execute = 1'b1;
    @(negedge clk);
    expect_result("b2b0", 32'd3, 5'd1);
    type_in = T_SUB; val1 = 32'd10; val2 = 32'd4; entry = 5'd2;
    @(negedge clk);
    execute = 1'b0;
    expect_result("b2b1", 32'd6, 5'd2);

    // rdy_in low stretches the pulse and freezes the result
    dispatch(T_ADD, 32'd100, 32'd23, 32'd0, 32'd0, 5'd17);
    rdy_in = 1'b0;
    repeat (2) @(negedge clk);
    expect_result("hold", 32'd123, 5'd17);
    rdy_in = 1'b1;
    @(negedge clk);
    check("hold_drop", {31'b0, aluReady}, 32'd0);

    // Flush in the dispatch cycle discards the instruction
    @(negedge clk);
    type_in = T_ADD; val1 = 32'd1; val2 = 32'd1; entry = 5'd18; execute = 1'b1; flush = 1'b1;
    @(negedge clk);
    execute = 1'b0; flush = 1'b0;
    check("flush_rdy", {31'b0, aluReady}, 32'd0);
    check("flush_val", val_out, 32'd123);

`ifdef ALU_MUL_EN
    run_mul("mulh",   T_MULH,   32'hFFFF_FFFE, 32'd3,        5'd19, 32'hFFFF_FFFF);
    run_mul("mul",    T_MUL,    32'd6,         32'd7,        5'd20, 32'd42);
    run_mul("mulhu",  T_MULHU,  32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h7FFF_FFFF);
    run_mul("mulhsu", T_MULHSU, 32'hFFFF_FFFF, 32'd2,        5'd22, 32'hFFFF_FFFF);
    begin
      int unsigned pulses;
      dispatch(T_MULH, 32'hFFFF_FFFE, 32'd3, 32'd0, 32'd0, 5'd23);
      repeat (9) @(negedge clk);
      check("mflush_busy_pre", {31'b0, busy}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("mflush_busy", {31'b0, busy}, 32'd0);
      check("mflush_rdy",  {31'b0, aluReady}, 32'd0);
      pulses = 0;
      repeat (40) begin
        @(negedge clk);
        if (aluReady) pulses++;
      end
      check("mflush_nopulse", pulses, 32'd0);
    end
`else
    dispatch(T_MUL, 32'd6, 32'd7, 32'd0, 32'd0, 5'd19);
    expect_result("nomul", 32'd0, 5'd19);
    check("nomul_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("nomul_drop", {31'b0, aluReady}, 32'd0);
    check("nomul_busy2", {31'b0, busy}, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
